// File: rtl/nco_sincos.sv
// Quadrature NCO: phase accumulator with shadowed tuning word, phase offset,
// quarter-wave sine table folded to full-wave signed sine/cosine outputs.
module nco_sincos #(
    parameter int WIDTH  = 16,
    parameter int WIDTHT = 11,
    parameter int WIDTHA = 32,
    parameter int ROUND  = 0
) (
    input  logic                     clock,
    input  logic                     clock_areset_n,
    input  logic                     enable,
    input  logic [WIDTHA-1:0]        ftw_in,
    input  logic                     ftw_load,
    input  logic [WIDTHT-1:0]        phase_offset,
    input  logic                     phase_sync,
    output logic signed [WIDTH-1:0]  sine_out,
    output logic signed [WIDTH-1:0]  cosine_out,
    output logic                     out_valid
);

    localparam int AW    = WIDTHT - 2;
    localparam int DEPTH = 2 ** AW;
    localparam longint PI_Q30 = 64'sd3373259426;

    // Quarter-wave entry k = round(A * sin((2k+1)*pi/(4*DEPTH))), A = 2**(WIDTH-1)-1.
    // Half-step sampling makes T[DEPTH-1-k] the exact cosine of entry k.
    function automatic logic [WIDTH-1:0] quarter_sine(input int k);
        longint x, x2, term, sum, amp, scaled;
        x    = ((64'sd2 * longint'(k) + 64'sd1) * PI_Q30) / (64'sd4 * longint'(DEPTH));
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        amp    = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
        scaled = (sum * amp + (64'sd1 <<< 29)) >>> 30;
        return scaled[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] lut_mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lut
            localparam logic [WIDTH-1:0] ENTRY = quarter_sine(gi);
            assign lut_mem[gi] = ENTRY;
        end
    endgenerate

    logic [WIDTHA-1:0] acc_reg;
    logic [WIDTHA-1:0] ftw_shadow_reg;
    logic [WIDTHA-1:0] ftw_active_reg;
    logic              ftw_pending_reg;
    logic [WIDTHT:0]   s0_phase_reg;
    logic [WIDTHT-1:0] s0_offset_reg;
    logic [WIDTHT-1:0] theta_reg;
    logic [AW-1:0]     sin_addr_reg;
    logic [AW-1:0]     cos_addr_reg;
    logic              sin_neg2_reg;
    logic              cos_neg2_reg;
    logic [WIDTH-1:0]  sin_mag_reg;
    logic [WIDTH-1:0]  cos_mag_reg;
    logic              sin_neg3_reg;
    logic              cos_neg3_reg;
    logic [3:0]        valid_reg;

    logic              launch;
    logic              round_bit;
    logic [WIDTHT-1:0] round_add;
    logic [1:0]        quad;
    logic [AW-1:0]     fine;

    assign launch    = enable & ~phase_sync;
    assign round_bit = (ROUND != 0) ? s0_phase_reg[0] : 1'b0;
    assign round_add = {{(WIDTHT-1){1'b0}}, round_bit};
    assign quad      = theta_reg[WIDTHT-1:WIDTHT-2];
    assign fine      = theta_reg[AW-1:0];

    // Stage 0: tuning-word handshake, accumulator and sample launch.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            acc_reg         <= '0;
            ftw_shadow_reg  <= '0;
            ftw_active_reg  <= '0;
            ftw_pending_reg <= 1'b0;
            s0_phase_reg    <= '0;
            s0_offset_reg   <= '0;
            valid_reg[0]    <= 1'b0;
        end else begin
            if (ftw_load)
                ftw_shadow_reg <= ftw_in;
            // The step in use this cycle is the old one; the new word takes over next sample.
            if (enable && ftw_pending_reg)
                ftw_active_reg <= ftw_shadow_reg;
            ftw_pending_reg <= ftw_load | (ftw_pending_reg & ~enable);
            if (phase_sync)
                acc_reg <= '0;
            else if (enable)
                acc_reg <= acc_reg + ftw_active_reg;
            if (launch) begin
                s0_phase_reg  <= acc_reg[WIDTHA-1 -: WIDTHT+1];
                s0_offset_reg <= phase_offset;
            end
            valid_reg[0] <= launch;
        end
    end

    // Stages 1-3: quantise and offset phase, fold to quarter wave, read table.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            theta_reg      <= '0;
            sin_addr_reg   <= '0;
            cos_addr_reg   <= '0;
            sin_neg2_reg   <= 1'b0;
            cos_neg2_reg   <= 1'b0;
            sin_mag_reg    <= '0;
            cos_mag_reg    <= '0;
            sin_neg3_reg   <= 1'b0;
            cos_neg3_reg   <= 1'b0;
            valid_reg[3:1] <= '0;
        end else begin
            theta_reg      <= s0_phase_reg[WIDTHT:1] + round_add + s0_offset_reg;
            sin_addr_reg   <= quad[0] ? ~fine : fine;
            cos_addr_reg   <= quad[0] ? fine : ~fine;
            sin_neg2_reg   <= quad[1];
            cos_neg2_reg   <= quad[1] ^ quad[0];
            sin_mag_reg    <= lut_mem[sin_addr_reg];
            cos_mag_reg    <= lut_mem[cos_addr_reg];
            sin_neg3_reg   <= sin_neg2_reg;
            cos_neg3_reg   <= cos_neg2_reg;
            valid_reg[3:1] <= valid_reg[2:0];
        end
    end

    // Stage 4: apply quadrant signs; outputs hold between samples.
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            sine_out   <= '0;
            cosine_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (valid_reg[3]) begin
                sine_out   <= sin_neg3_reg ? -$signed(sin_mag_reg) : $signed(sin_mag_reg);
                cosine_out <= cos_neg3_reg ? -$signed(cos_mag_reg) : $signed(cos_mag_reg);
            end
            out_valid <= valid_reg[3];
        end
    end

endmodule

// File: tb/tb_nco_sincos.sv
// Bench for nco_sincos: truncating and rounding instances share stimulus;
// expected samples are queued at launch and checked by an independent monitor.
module tb_nco_sincos;

    localparam real AMP = 32767.0;
    localparam real PI  = 3.14159265358979;

    logic               clock = 1'b0;
    logic               clock_areset_n = 1'b1;
    logic               enable = 1'b0;
    logic [31:0]        ftw_in = '0;
    logic               ftw_load = 1'b0;
    logic [10:0]        phase_offset = '0;
    logic               phase_sync = 1'b0;
    logic signed [15:0] sine_t, cosine_t, sine_r, cosine_r;
    logic               valid_t, valid_r;

    nco_sincos #(.WIDTH(16), .WIDTHT(11), .WIDTHA(32), .ROUND(0)) dut (
        .clock(clock), .clock_areset_n(clock_areset_n), .enable(enable),
        .ftw_in(ftw_in), .ftw_load(ftw_load), .phase_offset(phase_offset),
        .phase_sync(phase_sync), .sine_out(sine_t), .cosine_out(cosine_t),
        .out_valid(valid_t)
    );

    nco_sincos #(.WIDTH(16), .WIDTHT(11), .WIDTHA(32), .ROUND(1)) dut_round (
        .clock(clock), .clock_areset_n(clock_areset_n), .enable(enable),
        .ftw_in(ftw_in), .ftw_load(ftw_load), .phase_offset(phase_offset),
        .phase_sync(phase_sync), .sine_out(sine_r), .cosine_out(cosine_r),
        .out_valid(valid_r)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        int due;
        int theta_t;
        int theta_r;
    } sample_t;

    sample_t sb[$];
    int errors = 0;
    int checks = 0;

    // Reference model state: phase accumulator and tuning-word handshake.
    bit [31:0] m_acc = '0, m_shadow = '0, m_active = '0;
    bit        m_pending = 1'b0;
    real       last_st = 0.0, last_ct = 0.0, last_sr = 0.0, last_cr = 0.0;

    function automatic int theta_of(bit [31:0] acc, bit [10:0] off, bit rnd);
        longint a;
        a = longint'(acc);
        if (rnd) a = a + 64'sd1048576;
        return int'(((a / 64'sd2097152) + longint'(off)) % 64'sd2048);
    endfunction

    function automatic real ref_sin(int theta);
        return AMP * $sin(2.0 * PI * (real'(theta) + 0.5) / 2048.0);
    endfunction

    function automatic real ref_cos(int theta);
        return AMP * $cos(2.0 * PI * (real'(theta) + 0.5) / 2048.0);
    endfunction

    task automatic check_near(string name, int got, real want);
        real d;
        checks++;
        d = real'(got) - want;
        if (d > 1.0 || d < -1.0) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%.2f", name, cyc, got, want);
        end
    endtask

    task automatic check_eq(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // Drive one cycle of inputs, then advance the model by what that edge did.
    task automatic step(bit en, bit sync, bit load, bit [31:0] ftw, bit [10:0] off);
        bit [31:0] next_acc;
        sample_t   s;
        enable = en; phase_sync = sync; ftw_load = load; ftw_in = ftw; phase_offset = off;
        @(posedge clock);
        #1;
        if (clock_areset_n) begin
            if (en && !sync) begin
                s.due = cyc + 4;
                s.theta_t = theta_of(m_acc, off, 1'b0);
                s.theta_r = theta_of(m_acc, off, 1'b1);
                sb.push_back(s);
            end
            next_acc = sync ? 32'd0 : (en ? m_acc + m_active : m_acc);
            if (en && m_pending) m_active = m_shadow;
            m_pending = load || (m_pending && !en);
            if (load) m_shadow = ftw;
            m_acc = next_acc;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_acc = '0; m_shadow = '0; m_active = '0; m_pending = 1'b0;
        last_st = 0.0; last_ct = 0.0; last_sr = 0.0; last_cr = 0.0;
    endtask

    // Monitor: pop and compare whenever a sample strobes out.
    sample_t cur;
    always @(negedge clock) begin
        if (!clock_areset_n) begin
            check_eq("rst_valid", int'(valid_t), 0);
            check_eq("rst_valid_r", int'(valid_r), 0);
            check_eq("rst_sine", int'(sine_t), 0);
            check_eq("rst_cosine", int'(cosine_t), 0);
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                cur = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_strobe cyc=%0d got=none want_due=%0d", cyc, cur.due);
            end
            if (valid_t || valid_r) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe cyc=%0d got=%0b/%0b want=0", cyc, valid_t, valid_r);
                end else begin
                    cur = sb.pop_front();
                    check_eq("valid_pair", int'(valid_r), int'(valid_t));
                    last_st = ref_sin(cur.theta_t); last_ct = ref_cos(cur.theta_t);
                    last_sr = ref_sin(cur.theta_r); last_cr = ref_cos(cur.theta_r);
                    check_near("sine", int'(sine_t), last_st);
                    check_near("cosine", int'(cosine_t), last_ct);
                    check_near("sine_round", int'(sine_r), last_sr);
                    check_near("cosine_round", int'(cosine_r), last_cr);
                    $display("sample cyc=%0d theta=%0d/%0d sin=%0d cos=%0d sin_r=%0d cos_r=%0d",
                             cyc, cur.theta_t, cur.theta_r, sine_t, cosine_t, sine_r, cosine_r);
                end
            end else begin
                check_near("hold_sine", int'(sine_t), last_st);
                check_near("hold_cosine", int'(cosine_t), last_ct);
            end
        end
    end

    initial begin
        #1 clock_areset_n = 1'b0;
        // Reset held with enable high: nothing may come out.
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd0);
        clock_areset_n = 1'b1;
        model_reset();

        // Quarter-turn step: four quadrants in rotation.
        step(1'b0, 1'b0, 1'b1, 32'h4000_0000, 11'd0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd0);

        // Step of -1 LSB: theta crosses 0 -> 2047.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 11'd0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd0);

        // Accumulator exactly at FFF0_0000: rounding wraps theta to 0.
        step(1'b0, 1'b1, 1'b1, 32'hFFF0_0000, 11'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 11'd0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd0);

        // Zero step with fixed phase offsets.
        step(1'b0, 1'b1, 1'b1, 32'd0, 11'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 11'd0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd512);
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd1536);

        // Tuning word changed while running, then a 3-cycle enable gap.
        step(1'b0, 1'b1, 1'b1, 32'h0100_0000, 11'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 11'd0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd0);
        step(1'b1, 1'b0, 1'b1, 32'h0380_0000, 11'd0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0, 11'd0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd0);
        repeat (8) step(1'b0, 1'b0, 1'b0, 32'd0, 11'd0);

        // Phase sync mid-stream, then an asynchronous reset pulse mid-stream.
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 11'd0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd0);
        clock_areset_n = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0, 11'd0);
        clock_areset_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 32'h0123_4567, 11'd0);
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'd0, 11'd0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 15) == 0, $urandom, 11'($urandom_range(0, 2047)));
        end

        repeat (8) step(1'b0, 1'b0, 1'b0, 32'd0, 11'd0);
        check_eq("drain_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
